// File: rtl/seq_pattern_gen.sv
// Serial test-pattern transmitter: shifts a latched pattern out MSB-first, holding each bit
// stable before raising a step strobe, with auto-timed or manual-step pacing.
module seq_pattern_gen #(
  parameter int unsigned PAT_WIDTH   = 8,
  parameter int unsigned HALF_CYCLES = 4,
  parameter int unsigned LEN_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_manual,
  input  logic                 i_step,
  input  logic [PAT_WIDTH-1:0] i_pattern,
  input  logic [LEN_WIDTH-1:0] i_len,
  output logic                 o_bit_out,
  output logic                 o_next_out,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [LEN_WIDTH-1:0] o_bit_index,
  output logic [2:0]           o_state_display
);

  localparam int unsigned TW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [TW-1:0] TLoad = TW'(HALF_CYCLES - 1);
  localparam logic [LEN_WIDTH-1:0] PatW = LEN_WIDTH'(PAT_WIDTH);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSetup  = 3'd1,
    StStrobe = 3'd2,
    StDone   = 3'd3
  } state_e;

  state_e                 r_state, w_state_d;
  logic [TW-1:0]          r_timer, w_timer_d;
  logic [LEN_WIDTH-1:0]   r_bit_index, w_bit_index_d;
  logic [PAT_WIDTH-1:0]   r_pat, w_pat_d;
  logic                   r_manual, w_manual_d;
  logic                   r_step_last;
  logic                   r_bit_out, w_bit_out_d;
  logic                   r_next_out, w_next_out_d;
  logic                   r_busy, w_busy_d;
  logic                   r_done, w_done_d;

  logic                   w_step_rise;
  logic [LEN_WIDTH-1:0]   w_idx_load;

  assign w_step_rise = i_step & ~r_step_last;

  // Clamp len to 1..PAT_WIDTH and convert to the MSB index of the active window.
  assign w_idx_load = (i_len == '0)  ? '0 :
                      (i_len > PatW) ? PatW - 1'b1 :
                                       i_len - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_timer     <= '0;
      r_bit_index <= '0;
      r_pat       <= '0;
      r_manual    <= 1'b0;
      r_step_last <= 1'b0;
      r_bit_out   <= 1'b0;
      r_next_out  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_timer     <= w_timer_d;
      r_bit_index <= w_bit_index_d;
      r_pat       <= w_pat_d;
      r_manual    <= w_manual_d;
      r_step_last <= i_step;
      r_bit_out   <= w_bit_out_d;
      r_next_out  <= w_next_out_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_timer_d     = r_timer;
    w_bit_index_d = r_bit_index;
    w_pat_d       = r_pat;
    w_manual_d    = r_manual;
    case (r_state)
      StIdle: begin
        if (i_start && !i_abort) begin
          w_state_d     = StSetup;
          w_pat_d       = i_pattern;
          w_manual_d    = i_manual;
          w_bit_index_d = w_idx_load;
          w_timer_d     = TLoad;
        end
      end
      StSetup: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (r_manual) begin
          if (w_step_rise) begin
            w_state_d = StStrobe;
            w_timer_d = TLoad;
          end
        end else if (r_timer == '0) begin
          w_state_d = StStrobe;
          w_timer_d = TLoad;
        end else begin
          w_timer_d = r_timer - 1'b1;
        end
      end
      StStrobe: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (r_timer == '0) begin
          if (r_bit_index == '0) begin
            w_state_d = StDone;
          end else begin
            w_state_d     = StSetup;
            w_bit_index_d = r_bit_index - 1'b1;
            w_timer_d     = TLoad;
          end
        end else begin
          w_timer_d = r_timer - 1'b1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    w_busy_d     = (w_state_d == StSetup) || (w_state_d == StStrobe);
    w_next_out_d = (w_state_d == StStrobe);
    w_done_d     = (w_state_d == StDone);
    w_bit_out_d  = r_bit_out;
    if (w_state_d == StSetup) begin
      w_bit_out_d = |(w_pat_d & (PAT_WIDTH'(1) << w_bit_index_d));
    end
  end

  assign o_bit_out       = r_bit_out;
  assign o_next_out      = r_next_out;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_bit_index     = r_bit_index;
  assign o_state_display = r_state;

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial test-pattern transmitter that drives a sequence detector's bit input and step strobe. It emits a stored pattern one bit per step, MSB of the active window first. For each bit it holds `bit_out` stable, then pulses `next_out` high, so a receiver that samples its bit input on a rising edge of its step signal sees exactly one bit per pulse. It can run in a free-running (auto-timed) mode or advance on a manual step button.

Parameters:
- PAT_WIDTH, 8: pattern register width; maximum sequence length.
- HALF_CYCLES, 4: clock cycles spent in each of SETUP and STROBE (auto mode). Must be at least 1.
- LEN_WIDTH, 4: width of the `len` input. Must satisfy 2^LEN_WIDTH > PAT_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; sampled only in IDLE; begins a transmission
- abort  in  1  level; terminates any transmission
- manual  in  1  sampled at start: 1 = SETUP ends on a step rising edge, 0 = SETUP is timed
- step  in  1  manual step button (already debounced)
- pattern  in  PAT_WIDTH  bits to send; captured at start
- len  in  LEN_WIDTH  number of bits to send; captured at start
- bit_out  out  1  serial data bit to the receiver's bit input
- next_out  out  1  step strobe to the receiver's step input
- busy  out  1  high in SETUP and STROBE
- done  out  1  one-cycle pulse when the last bit's strobe completes
- bit_index  out  LEN_WIDTH  index of the bit currently driven
- state_display  out  3  current FSM state code

Behaviour:
- All outputs are registered.
- Reset values: `bit_out`=0, `next_out`=0, `busy`=0, `done`=0, `bit_index`=0, `state_display`=0. State=IDLE, timer=0, `step_last`=0.
- Reset has priority over everything and can occur in any state, including mid-transmission. `next_out` is low the cycle after reset.
- State codes: IDLE=0, SETUP=1, STROBE=2, DONE=3. Codes 4–7 are illegal and go to IDLE on the next cycle.
- IDLE:
  - On `start`=1, latch `pattern` into `pat_reg` and latch `manual`.
  - Effective length L = `len` clamped to 1..PAT_WIDTH (`len`=0 gives L=1; `len`>PAT_WIDTH gives L=PAT_WIDTH).
  - Set `bit_index` = L-1, load timer = HALF_CYCLES-1, go to SETUP.
- SETUP:
  - `bit_out` = `pat_reg[bit_index]`, `next_out`=0, `busy`=1.
  - Auto mode: count the timer down; when timer=0, go to STROBE and reload timer.
  - Manual mode: the timer is ignored; go to STROBE on the cycle a step rising edge is seen (`step`=1 and `step_last`=0).
- STROBE:
  - `next_out`=1, `bit_out` unchanged, lasting exactly HALF_CYCLES cycles in both modes.
  - At the end: if `bit_index`=0, go to DONE; otherwise decrement `bit_index`, reload timer, go to SETUP.
- DONE: `done`=1 for one cycle, `busy`=0, `next_out`=0, `bit_out` holds the last bit. Next state is IDLE.
- Data stability: `bit_out` changes only on entry to SETUP, never while `next_out`=1 and never on the cycle `next_out` rises.
- Auto timing (start sampled at edge T):
  - First SETUP occupies cycles T+1..T+H; first STROBE occupies T+H+1..T+2H.
  - `done` is asserted at cycle T+1+2·H·L.
- `step_last` updates every cycle in all states. A step that is already high at the start of SETUP does not advance; a fresh rising edge is required.
- `abort`=1 in SETUP, STROBE or DONE: next state is IDLE, `next_out`=0, `busy`=0, no `done` pulse.
- `abort` and `start` both high in IDLE: abort wins and the block stays in IDLE.
- `start` outside IDLE is ignored. `pattern`, `len` and `manual` changes during a transmission have no effect.
- `start` held high through DONE: a new transmission begins from IDLE one cycle after DONE.

Test Plan:
1. Auto, HALF_CYCLES=4, `pattern`=8'hA5, `len`=8 -> `bit_out` sequence 1,0,1,0,0,1,0,1; 8 `next_out` pulses of 4 cycles each with 4 low cycles between; `done` at start+65; `busy` falls at the same time.
2. Length clamp: `len`=0 with `pattern`=8'h01 -> exactly 1 pulse with `bit_out`=1. `len`=15 -> exactly 8 pulses.
3. Manual mode, `pattern`=8'b110, `len`=3:
   - Block stays in SETUP until step edges; 3 edges produce bits 1,1,0.
   - Holding `step` high produces only one advance.
   - A step edge during STROBE is ignored.
4. Abort: `abort` during STROBE of bit 3 of 8 -> IDLE next cycle, `next_out`=0, no `done`. A new `start` then transmits all 8 bits from the MSB.
5. Reset mid-transmission, and `start` while busy:
   - Reset during SETUP -> all outputs zero next cycle.
   - Pulsing `start` with a new pattern while busy does not alter the current bits.
6. Loopback into the sequence detector: drive its bit input from `bit_out` and its step input from `next_out`, send `pattern`=8'b10 with `len`=2 -> detector reaches state 3 and its output is high after the second pulse.
